abus_slave: RTL and testbench

//  Responder end of the abus. Decodes a master request (write/read/abort) in its

---
 rtl/abus_slave.sv | 187 ++++++++++++++++++
 tb/tb_abus_slave.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/abus_slave.sv
// abus responder: IDLE (decode window) | ACCESS (local strobe held, timeout count) | RESP (ack held until sreq drops).
// Returns are zero whenever idle so the interconnect can OR all slaves together.
module abus_slave #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    WIN_BITS   = 8,
  parameter int                    TIMEOUT    = 15,
  localparam int                   SW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  abus_clk,
  input  logic                  abus_rstb,
  input  logic                  abus_sreq,
  input  logic                  abus_sgrant,
  input  logic                  abus_swrite,
  input  logic                  abus_sread,
  input  logic                  abus_sabort,
  input  logic [ADDR_WIDTH-1:0] abus_saddress,
  input  logic [DATA_WIDTH-1:0] abus_swdata,
  input  logic [SW-1:0]         abus_sstrb,
  input  logic [SW-1:0]         abus_skeep,
  output logic                  abus_sack,
  output logic                  abus_serr,
  output logic [DATA_WIDTH-1:0] abus_srdata,
  output logic                  reg_write,
  output logic                  reg_read,
  output logic [WIN_BITS-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [DATA_WIDTH-1:0] reg_wmask,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ready,
  input  logic                  reg_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  is_read_q, is_read_d;
  logic [SW-1:0]         keep_q, keep_d;
  logic                  sack_q, sack_d;
  logic                  serr_q, serr_d;
  logic [DATA_WIDTH-1:0] srdata_q, srdata_d;
  logic                  reg_write_q, reg_write_d;
  logic                  reg_read_q, reg_read_d;
  logic [WIN_BITS-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_WIDTH-1:0] reg_wmask_q, reg_wmask_d;
  logic                  hit;
  logic                  go_idle;

  // Lane count to LSB mask; counts of DATA_WIDTH or more give all ones.
  function automatic logic [DATA_WIDTH-1:0] len_mask(input logic [SW-1:0] n);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = (32'(n) > 32'(i));
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_read_d   = is_read_q;
    keep_d      = keep_q;
    sack_d      = sack_q;
    serr_d      = serr_q;
    srdata_d    = srdata_q;
    reg_write_d = reg_write_q;
    reg_read_d  = reg_read_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wmask_d = reg_wmask_q;
    go_idle     = 1'b0;
    hit = abus_sreq & abus_sgrant &
          (abus_saddress[ADDR_WIDTH-1:WIN_BITS] == BASE_ADDR[ADDR_WIDTH-1:WIN_BITS]);

    case (state_q)
      S_IDLE: begin
        if (hit && abus_sabort) begin
          state_d  = S_RESP;
          sack_d   = 1'b1;
          serr_d   = 1'b0;
          srdata_d = '0;
        end else if (hit && abus_swrite) begin
          state_d     = S_ACCESS;
          cnt_d       = '0;
          is_read_d   = 1'b0;
          reg_write_d = 1'b1;
          reg_addr_d  = abus_saddress[WIN_BITS-1:0];
          reg_wdata_d = abus_swdata;
          reg_wmask_d = len_mask(abus_sstrb);
        end else if (hit && abus_sread) begin
          state_d     = S_ACCESS;
          cnt_d       = '0;
          is_read_d   = 1'b1;
          keep_d      = abus_skeep;
          reg_read_d  = 1'b1;
          reg_addr_d  = abus_saddress[WIN_BITS-1:0];
          reg_wdata_d = '0;
          reg_wmask_d = '0;
        end
      end
      S_ACCESS: begin
        // A vanished master outranks everything: nobody is left to take the ack.
        if (!abus_sreq) begin
          go_idle = 1'b1;
        end else if (reg_ready) begin
          state_d     = S_RESP;
          reg_write_d = 1'b0;
          reg_read_d  = 1'b0;
          sack_d      = 1'b1;
          serr_d      = reg_err;
          srdata_d    = is_read_q ? (reg_rdata & len_mask(keep_q)) : '0;
        end else if (abus_sabort || (cnt_q == CW'(TIMEOUT))) begin
          state_d     = S_RESP;
          reg_write_d = 1'b0;
          reg_read_d  = 1'b0;
          sack_d      = 1'b1;
          serr_d      = !abus_sabort;
          srdata_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (!abus_sreq) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      is_read_d   = 1'b0;
      keep_d      = '0;
      sack_d      = 1'b0;
      serr_d      = 1'b0;
      srdata_d    = '0;
      reg_write_d = 1'b0;
      reg_read_d  = 1'b0;
      reg_addr_d  = '0;
      reg_wdata_d = '0;
      reg_wmask_d = '0;
    end
  end

  always_ff @(posedge abus_clk) begin
    if (!abus_rstb) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_read_q   <= 1'b0;
      keep_q      <= '0;
      sack_q      <= 1'b0;
      serr_q      <= 1'b0;
      srdata_q    <= '0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_read_q   <= is_read_d;
      keep_q      <= keep_d;
      sack_q      <= sack_d;
      serr_q      <= serr_d;
      srdata_q    <= srdata_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wmask_q <= reg_wmask_d;
    end
  end

  assign abus_sack   = sack_q;
  assign abus_serr   = serr_q;
  assign abus_srdata = srdata_q;
  assign reg_write   = reg_write_q;
  assign reg_read    = reg_read_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wmask   = reg_wmask_q;

endmodule

// File: tb/tb_abus_slave.sv
// Directed bench for abus_slave: expected responses are queued when a request
// is driven and compared when the slave raises abus_sack.
module tb_abus_slave;
  localparam int          AW   = 16;
  localparam int          DW   = 16;
  localparam int          WB   = 8;
  localparam int          TO   = 15;
  localparam int          SW   = $clog2(DW + 1);
  localparam logic [15:0] BASE = 16'h0400;

  logic          clk = 1'b0;
  logic          rstb;
  logic          sreq, sgrant, swrite, sread, sabort;
  logic [AW-1:0] saddr;
  logic [DW-1:0] swdata;
  logic [SW-1:0] sstrb, skeep;
  logic          sack, serr;
  logic [DW-1:0] srdata;
  logic          reg_write, reg_read;
  logic [WB-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_wmask, reg_rdata;
  logic          reg_ready, reg_err;

  always #5 clk = ~clk;

  abus_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .WIN_BITS(WB), .TIMEOUT(TO)
  ) dut (
    .abus_clk(clk), .abus_rstb(rstb), .abus_sreq(sreq), .abus_sgrant(sgrant),
    .abus_swrite(swrite), .abus_sread(sread), .abus_sabort(sabort),
    .abus_saddress(saddr), .abus_swdata(swdata), .abus_sstrb(sstrb), .abus_skeep(skeep),
    .abus_sack(sack), .abus_serr(serr), .abus_srdata(srdata),
    .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wmask(reg_wmask), .reg_rdata(reg_rdata),
    .reg_ready(reg_ready), .reg_err(reg_err)
  );

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [DW-1:0] exp_mask(input int n);
    logic [DW:0] t;
    if (n >= DW) return {DW{1'b1}};
    t = (17'd1 << n) - 17'd1;
    return t[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // op: 0 write, 1 read, 2 abort; returns just after the capturing edge
  task automatic req(input int op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input int strb, input int keep);
    sreq = 1'b1; sgrant = 1'b1;
    swrite = (op == 0); sread = (op == 1); sabort = (op == 2);
    saddr = a; swdata = wd; sstrb = SW'(strb); skeep = SW'(keep);
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic e, input logic [DW-1:0] d);
    sb_q.push_back({e, d});
  endtask

  task automatic wait_ack(input string tag, input int exp_edges);
    int   n;
    exp_t e;
    n = 0;
    while (!sack && n < 40) begin
      @(posedge clk); #1;
      reg_ready = 1'b0;
      n++;
    end
    check({tag, "_lat"}, n, exp_edges);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_serr"}, serr, e.err);
      check({tag, "_srdata"}, srdata, e.data);
    end
  endtask

  task automatic release_bus(input string tag);
    sreq = 1'b0; sgrant = 1'b0; swrite = 1'b0; sread = 1'b0; sabort = 1'b0;
    reg_ready = 1'b0; reg_err = 1'b0;
    @(posedge clk); #1;
    check({tag, "_rel_sack"}, sack, 0);
    check({tag, "_rel_serr"}, serr, 0);
    check({tag, "_rel_srdata"}, srdata, 0);
    check({tag, "_rel_strobes"}, {reg_write, reg_read}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rstb = 1'b0; sreq = 0; sgrant = 0; swrite = 0; sread = 0; sabort = 0;
    saddr = '0; swdata = '0; sstrb = '0; skeep = '0;
    reg_rdata = '0; reg_ready = 0; reg_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sack", sack, 0);
    check("rst_serr", serr, 0);
    check("rst_srdata", srdata, 0);
    check("rst_strobes", {reg_write, reg_read}, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_wmask", reg_wmask, 0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // write 0x1234 to BASE+3, ready after two wait cycles
    req(0, BASE + 16'd3, 16'h1234, 16, 0);
    check("w1_wr", reg_write, 1);
    check("w1_addr", reg_addr, 3);
    check("w1_wdata", reg_wdata, 16'h1234);
    check("w1_wmask", reg_wmask, exp_mask(16));
    push_exp(1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("w1_wait_wr", reg_write, 1);
    check("w1_wait_sack", sack, 0);
    reg_ready = 1'b1;
    wait_ack("w1", 1);
    check("w1_ack_wr", reg_write, 0);
    release_bus("w1");

    // zero-wait read, keep 8
    req(1, BASE + 16'd5, 16'h0, 0, 8);
    check("r1_rd", reg_read, 1);
    check("r1_addr", reg_addr, 5);
    reg_rdata = 16'hBEEF; reg_ready = 1'b1;
    push_exp(1'b0, 16'hBEEF & exp_mask(8));
    wait_ack("r1", 1);
    check("r1_ack_rd", reg_read, 0);
    release_bus("r1");

    // just outside the window, then in-window without grant
    sreq = 1'b1; sgrant = 1'b1; swrite = 1'b1; saddr = BASE + 16'h0100; sstrb = SW'(16);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("oow_strobes", {reg_write, reg_read}, 0);
      check("oow_sack", sack, 0);
    end
    saddr = BASE + 16'd1; sgrant = 1'b0;
    @(posedge clk); #1;
    check("nogrant_wr", reg_write, 0);
    release_bus("oow");

    // ready never comes: timeout error
    req(1, BASE + 16'd7, 16'h0, 0, 16);
    push_exp(1'b1, 16'h0000);
    wait_ack("to", TO + 1);
    check("to_rd", reg_read, 0);
    release_bus("to");

    // abort while the local access is pending
    req(1, BASE + 16'd9, 16'h0, 0, 16);
    @(posedge clk); #1;
    sabort = 1'b1;
    push_exp(1'b0, 16'h0000);
    wait_ack("ab", 1);
    check("ab_rd", reg_read, 0);
    release_bus("ab");

    // ready, reg_err and abort in the same cycle: ready wins
    req(0, BASE + 16'h10, 16'hA5A5, 4, 0);
    check("rea_wmask", reg_wmask, exp_mask(4));
    reg_ready = 1'b1; reg_err = 1'b1; sabort = 1'b1;
    push_exp(1'b1, 16'h0000);
    wait_ack("rea", 1);
    release_bus("rea");

    // zero-length write
    req(0, BASE + 16'hFF, 16'hFFFF, 0, 0);
    check("s0_wr", reg_write, 1);
    check("s0_addr", reg_addr, 8'hFF);
    check("s0_wmask", reg_wmask, 0);
    reg_ready = 1'b1;
    push_exp(1'b0, 16'h0000);
    wait_ack("s0", 1);
    release_bus("s0");

    // full-width read with local error
    req(1, BASE + 16'd2, 16'h0, 0, 16);
    reg_rdata = 16'h8001; reg_ready = 1'b1; reg_err = 1'b1;
    push_exp(1'b1, 16'h8001);
    wait_ack("re", 1);
    release_bus("re");

    // abort straight from idle, then reset while in RESP
    req(2, BASE + 16'd1, 16'h0, 0, 0);
    check("ai_strobes", {reg_write, reg_read}, 0);
    push_exp(1'b0, 16'h0000);
    wait_ack("ai", 0);
    rstb = 1'b0;
    @(posedge clk); #1;
    check("rresp_sack", sack, 0);
    release_bus("rresp");
    rstb = 1'b1;
    @(posedge clk); #1;

    // reset while a local write is pending
    req(0, BASE + 16'd4, 16'h5555, 16, 0);
    check("racc_wr_pre", reg_write, 1);
    rstb = 1'b0;
    @(posedge clk); #1;
    check("racc_wr", reg_write, 0);
    check("racc_addr", reg_addr, 0);
    check("racc_wmask", reg_wmask, 0);
    check("racc_sack", sack, 0);
    release_bus("racc");
    rstb = 1'b1;
    @(posedge clk); #1;

    // master vanishes mid-access: no ack ever
    req(1, BASE + 16'd6, 16'h0, 0, 16);
    sreq = 1'b0; sgrant = 1'b0; sread = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("van_rd", reg_read, 0);
      check("van_sack", sack, 0);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
